// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared arithmetic definitions for the bit-serial subtractor. The default
// width matches the combinational ripple adder that sits beside it, so both
// units agree on operand size without extra plumbing.
//   - state_e        : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH  : operand / result width
//   - DEFAULT_CNT_W  : bit-counter width, smallest value with 2^CNT_W > WIDTH
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // A counter of this width can represent WIDTH, which keeps 2^CNT_W > WIDTH.
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start/busy/done handshake plus operand and result buses for the serial
// subtractor.
//   start     : request, honoured only while busy is low
//   A, B      : minuend / subtrahend, captured on the accepted start edge
//   D         : registered difference A-B mod 2^WIDTH
//   Bout      : final borrow (A < B unsigned)
//   Ovf       : signed overflow
//   busy      : high while bits are being processed
//   done      : one-cycle pulse when D/Bout/Ovf are updated
// Modports: master drives requests, slave (the subtractor) answers.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  D, Bout, Ovf, busy, done
  );

  modport slave (
    input  start, A, B,
    output D, Bout, Ovf, busy, done
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full-subtractor cell, the counterpart of the ripple adder's
// full-adder cell. Purely combinational.
//   a, b  : minuend / subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow leaves this bit when b exceeds a outright, or when the bits are
  // equal and a borrow is already coming in from below.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor, D = A - B, LSB first, one bit per
// clock through a single full-subtractor cell. Chosen where area matters more
// than latency: WIDTH clocks from accepted start to done.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of serial_subtractor_if (start/A/B in,
//            D/Bout/Ovf/busy/done out)
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cellD;
  logic             cellBout;
  logic [WIDTH-1:0] resFull;

  full_subtractor u_cell (
    .a    (aShift_q[0]),
    .b    (bShift_q[0]),
    .bin  (borrow_q),
    .d    (cellD),
    .bout (cellBout)
  );

  // The new difference bit enters at the top; after WIDTH shifts the
  // partial result plus the last bit form the complete difference.
  assign resFull = {cellD, res_q};

  // Next-state logic. Operand MSBs are saved at capture because the shift
  // registers have discarded them by the time overflow is evaluated. The
  // visible result registers only change on the final bit, so the previous
  // answer stays readable while the next one is being computed.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    dOut_d   = dOut_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          aShift_d = bus.A;
          bShift_d = bus.B;
          aMsb_d   = bus.A[WIDTH-1];
          bMsb_d   = bus.B[WIDTH-1];
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        res_d    = resFull[WIDTH-1:1];
        borrow_d = cellBout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          dOut_d  = resFull;
          bout_d  = cellBout;
          ovf_d   = (aMsb_q ^ bMsb_q) & (cellD ^ aMsb_q);
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so an aborted
  // operation leaves no trace and produces no done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      dOut_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      dOut_q   <= dOut_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.D    = dOut_q;
  assign bus.Bout = bout_q;
  assign bus.Ovf  = ovf_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). Stimulus pushes the
// hand-computed expected result into a scoreboard queue; an independent
// monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } result_t;

  logic clk;
  logic rst_n;

  int tests;
  int failed;

  result_t          expQ[$];
  logic [WIDTH-1:0] heldD;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse and checks that the
  // published result stays frozen at the last expected value while busy.
  always @(negedge clk) begin
    result_t exp;
    if (!rst_n) begin
      heldD = '0;
    end else if (bus.done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("D",    32'(bus.D),    32'(exp.d));
        checkOutput("Bout", 32'(bus.Bout), 32'(exp.bout));
        checkOutput("Ovf",  32'(bus.Ovf),  32'(exp.ovf));
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        heldD = exp.d;
      end
    end else if (bus.busy) begin
      checkOutput("D_held_while_busy", 32'(bus.D), 32'(heldD));
    end
  end

  // Waits for the done pulse after an accepted start, counting busy cycles.
  task automatic waitDone(input string name);
    int  busyCycles;
    bit  seen;
    busyCycles = 0;
    seen       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'(WIDTH));
  endtask

  // Issues one operation from idle and waits for its completion.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] expD, input logic expB,
                               input logic expO, input string name);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    expQ.push_back('{d: expD, bout: expB, ovf: expO});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(name);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_D",    32'(bus.D),    32'd0);
    checkOutput("rst_Bout", 32'(bus.Bout), 32'd0);
    checkOutput("rst_Ovf",  32'(bus.Ovf),  32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    // Directed vectors: A, B -> D, Bout, Ovf.
    applyStimulus(8'd100, 8'd55,  8'd45,  1'b0, 1'b0, "basic");
    applyStimulus(8'd10,  8'd30,  8'd236, 1'b1, 1'b0, "borrow");
    applyStimulus(8'd0,   8'd1,   8'd255, 1'b1, 1'b0, "wrap");
    applyStimulus(8'd128, 8'd1,   8'd127, 1'b0, 1'b1, "ovf_neg");
    applyStimulus(8'd127, 8'd255, 8'd128, 1'b1, 1'b1, "ovf_pos");
    applyStimulus(8'd255, 8'd255, 8'd0,   1'b0, 1'b0, "equal");
    applyStimulus(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, "zero");

    // Back-to-back: start held high, new operands presented during SHIFT
    // are ignored there and picked up at the DONE cycle.
    @(negedge clk);
    bus.A     = 8'd50;
    bus.B     = 8'd20;
    bus.start = 1'b1;
    expQ.push_back('{d: 8'd30, bout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1;
    bus.A = 8'd20;
    bus.B = 8'd50;
    expQ.push_back('{d: 8'd226, bout: 1'b1, ovf: 1'b0});
    waitDone("b2b_1");
    @(posedge clk);
    #1;
    bus.A = 8'd3;
    bus.B = 8'd3;
    expQ.push_back('{d: 8'd0, bout: 1'b0, ovf: 1'b0});
    waitDone("b2b_2");
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone("b2b_3");
    @(negedge clk);
    checkOutput("b2b_done_drops", 32'(bus.done), 32'd0);

    // Start pulsed mid-SHIFT with other operands must be ignored.
    @(negedge clk);
    bus.A     = 8'd90;
    bus.B     = 8'd40;
    bus.start = 1'b1;
    expQ.push_back('{d: 8'd50, bout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.A     = 8'd1;
    bus.B     = 8'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    checkOutput("ignore_done_seen", 32'(bus.done), 32'd1);

    // Reset during the 4th SHIFT cycle aborts the operation with no done.
    @(negedge clk);
    bus.A     = 8'd60;
    bus.B     = 8'd10;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_D",    32'(bus.D),    32'd0);
    checkOutput("midrst_Bout", 32'(bus.Bout), 32'd0);
    checkOutput("midrst_Ovf",  32'(bus.Ovf),  32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("midrst_still_idle", 32'(bus.busy), 32'd0);

    // Fresh operation after the abort.
    applyStimulus(8'd200, 8'd100, 8'd100, 1'b0, 1'b1, "after_rst");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
